midi_note_gate: RTL and testbench
=================================

# midi_note_gate

Producer side of the envelope follower's input interface. Parses a MIDI byte stream into a monophonic note gate (playing flag, velocity, note number) and generates a sawtooth sample stream with a sample-ready strobe at a fixed divided rate. Sits between the MIDI UART receiver and the envelope follower, driving its sample, sample-ready, playing and velocity inputs.

## Interface
- SAMPLE_DIV, 1134: clocks per sample tick (1134 ≈ 44.1 kHz from 50 MHz); legal range 2..65535.
- CHANNEL, 0: MIDI channel (0..15) accepted when omni mode is compiled out.
- inClk  in  1  single clock; all logic on its rising edge.
- inResetN  in  1  asynchronous, active-low reset; deassertion is synchronous to inClk.
- inMidiByte  in  8  received MIDI byte.
- inMidiByteReady  in  1  one-cycle strobe; inMidiByte valid this cycle; one byte per cycle max, no backpressure.
- outSample  out  12  unsigned sample; 12'h800 is silence.
- outSampleReady  out  1  one-cycle pulse per sample tick.
- outIsPlaying  out  1  note gate.
- outVelocity  out  7  velocity of the current or last note.
- outNote  out  7  key number of the current or last note.

## Operation
- Reset values: outSample=12'h800, outSampleReady=0, outIsPlaying=0, outVelocity=0, outNote=0; divider=0, phase=0, running status cleared, FSM=ST_NONE.
- Parser FSM states: ST_NONE (no running status), ST_KEY (expect key byte), ST_VEL (expect velocity byte), ST_SKIP1 (discard 1 more data byte), ST_SKIP2 (discard 2 more).
- Bytes 0xF8..0xFF (real-time): ignored in every state; no state change.
- Bytes 0xF0..0xF7: clear running status -> ST_NONE.
- Status 0x8n/0x9n, n matching the channel: latch status -> ST_KEY. Status 0xCn/0xDn -> ST_SKIP1. Other 0x8n..0xEn (incl. note messages on a non-matching channel) -> ST_SKIP2.
- Data byte (bit7=0): ST_KEY latches key -> ST_VEL. ST_VEL executes the message -> ST_KEY (running status). ST_SKIP1 -> ST_SKIP1 (re-arm for running status). ST_SKIP2 -> ST_SKIP1 on the first data byte; on the second, back to ST_SKIP2. ST_NONE ignores data bytes.
- Note-on with vel>0: outNote=key, outVelocity=vel, outIsPlaying=1, phase zeroed (last-note priority; retrigger allowed).
- Note-off (0x8n any velocity, or 0x9n with vel=0): if key==outNote, outIsPlaying=0; otherwise ignored. outNote/outVelocity are retained.
- Oscillator: 24-bit phase accumulator; on each tick while playing, phase += INC[outNote]. outSample=phase[23:12] while playing, 12'h800 when not. Phase holds while not playing.

## Timing
- Gate outputs update on the clock edge after the cycle in which the velocity byte's strobe is sampled (1-cycle latency).
- Divider counts 0..SAMPLE_DIV-1. outSampleReady pulses in the cycle after the count reaches SAMPLE_DIV-1, and pulses continuously whether or not a note is playing. outSample updates on the same edge as the pulse and is stable until the next pulse.
- Collision between a note-on and a tick in the same cycle: the tick outputs a sample computed from the pre-update phase and note. Phase zeroing wins over the increment.
- Reset asserted mid-message or mid-note returns all state to reset values immediately. The first tick after deassertion occurs SAMPLE_DIV cycles later.

## Configuration
- MIDI_OMNI_EN defined: channel nibble ignored; note messages on all 16 channels are accepted, and CHANNEL is unused.
- MIDI_OMNI_EN undefined: only channel CHANNEL is accepted; note messages on other channels are skipped as two-data-byte messages.

## Structure
- Shared package midi_synth_pkg: MIDI status constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG=4'hC, CHAN_PRESS=4'hD), FSM state enum, SILENCE=12'h800, and the 128-entry 24-bit increment table INC[k]=round(440·2^((k-69)/12)·2^24/44100).
- One sub-module, note_increment_rom: combinational 7-bit key -> 24-bit increment lookup on the table.

## Test plan
- Reset, then run 3·SAMPLE_DIV cycles with SAMPLE_DIV=4 -> outSampleReady pulses every 4 cycles; outSample=12'h800, outIsPlaying=0.
- Bytes 0x90,0x45,0x64 -> outIsPlaying=1, outNote=69, outVelocity=100 one cycle after the last strobe; successive samples step by INC[69]>>12 with phase carry.
- Running status 0x90,0x3C,0x40,0x40,0x00 -> note 60 on (vel 64), then note 64 with vel 0 is a no-op, so the gate stays 1. Then 0x80,0x3C,0x00 -> outIsPlaying=0, outNote=60 retained, outSample=12'h800.
- 0x90,0x3C, then 0xF8, then 0x50 -> real-time byte ignored; note 60 on with vel 80. 0xC0,0x05,0x07 (two program changes) -> gate unchanged.
- Without MIDI_OMNI_EN, CHANNEL=0: 0x91,0x3C,0x40 -> ignored. With MIDI_OMNI_EN -> note 60 on.
- Note-on velocity byte strobed in the same cycle the divider wraps -> that tick's sample uses the old phase, and the next sample equals INC[key]>>12. Reset pulse mid-note -> all outputs return to reset values.

Source files
------------

// File: rtl/midi_synth_pkg.sv
// Shared MIDI synth definitions: status nibbles, parser states, silence level
// and the per-key 24-bit phase increment table (44.1 kHz sample rate, A4 = key 69 = 440 Hz).
package midi_synth_pkg;

    localparam int unsigned DIV_W    = 16;
    localparam int unsigned PHASE_W  = 24;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned KEY_W    = 7;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;

    localparam logic [SAMPLE_W-1:0] SILENCE = 12'h800;

    typedef enum logic [2:0] {
        ST_NONE,
        ST_KEY,
        ST_VEL,
        ST_SKIP1,
        ST_SKIP2
    } parse_state_t;

    typedef logic [127:0][PHASE_W-1:0] inc_table_t;

    // Elaboration-time table: round(440 * 2^((k-69)/12) * 2^24 / 44100).
    function automatic inc_table_t build_inc_table();
        inc_table_t t;
        real        f;
        for (int k = 0; k < 128; k++) begin
            f    = 440.0 * (2.0 ** ((real'(k) - 69.0) / 12.0)) * 16777216.0 / 44100.0;
            t[k] = PHASE_W'($rtoi(f + 0.5));
        end
        return t;
    endfunction

    localparam inc_table_t INC = build_inc_table();

endpackage

// File: rtl/note_increment_rom.sv
// Combinational key -> sawtooth phase increment lookup.
module note_increment_rom
    import midi_synth_pkg::*;
(
    input  logic [KEY_W-1:0]   key,
    output logic [PHASE_W-1:0] inc
);

    assign inc = INC[key];

endmodule

// File: rtl/midi_note_gate.sv
// MIDI byte stream -> monophonic note gate plus sawtooth sample stream.
// Optional MIDI_OMNI_EN: accept note messages on every channel.
module midi_note_gate
    import midi_synth_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1134,
    parameter int unsigned CHANNEL    = 0
) (
    input  logic                inClk,
    input  logic                inResetN,
    input  logic [7:0]          inMidiByte,
    input  logic                inMidiByteReady,
    output logic [SAMPLE_W-1:0] outSample,
    output logic                outSampleReady,
    output logic                outIsPlaying,
    output logic [KEY_W-1:0]    outVelocity,
    output logic [KEY_W-1:0]    outNote
);

    parse_state_t         state, state_next;
    logic [KEY_W-1:0]     key_q, key_next;
    logic                 status_on_q, status_on_next;
    logic                 skip_two_q, skip_two_next;
    logic                 note_on_c, note_off_c;
    logic                 chan_ok_c;

    logic [DIV_W-1:0]     div_q;
    logic                 tick_c;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   inc_c;
    logic [PHASE_W-1:0]   sum_c;

`ifdef MIDI_OMNI_EN
    assign chan_ok_c = 1'b1;
`else
    assign chan_ok_c = (inMidiByte[3:0] == 4'(CHANNEL));
`endif

    // Parser state registers
    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            state       <= ST_NONE;
            key_q       <= '0;
            status_on_q <= 1'b0;
            skip_two_q  <= 1'b0;
        end else begin
            state       <= state_next;
            key_q       <= key_next;
            status_on_q <= status_on_next;
            skip_two_q  <= skip_two_next;
        end
    end

    // skip_two remembers the skipped message length so running status of a
    // two-data-byte message returns from ST_SKIP1 to ST_SKIP2.
    always_comb begin
        state_next     = state;
        key_next       = key_q;
        status_on_next = status_on_q;
        skip_two_next  = skip_two_q;
        note_on_c      = 1'b0;
        note_off_c     = 1'b0;
        if (inMidiByteReady) begin
            if (inMidiByte[7]) begin
                if (inMidiByte[7:3] == 5'b11111) begin
                    state_next = state;
                end else if (inMidiByte[7:4] == 4'hF) begin
                    state_next = ST_NONE;
                end else begin
                    case (inMidiByte[7:4])
                        NOTE_OFF, NOTE_ON: begin
                            if (chan_ok_c) begin
                                state_next     = ST_KEY;
                                status_on_next = inMidiByte[4];
                            end else begin
                                state_next    = ST_SKIP2;
                                skip_two_next = 1'b1;
                            end
                        end
                        PROG, CHAN_PRESS: begin
                            state_next    = ST_SKIP1;
                            skip_two_next = 1'b0;
                        end
                        default: begin
                            state_next    = ST_SKIP2;
                            skip_two_next = 1'b1;
                        end
                    endcase
                end
            end else begin
                case (state)
                    ST_KEY: begin
                        key_next   = inMidiByte[6:0];
                        state_next = ST_VEL;
                    end
                    ST_VEL: begin
                        state_next = ST_KEY;
                        if (status_on_q && (inMidiByte[6:0] != 7'd0)) begin
                            note_on_c = 1'b1;
                        end else begin
                            note_off_c = 1'b1;
                        end
                    end
                    ST_SKIP1: state_next = skip_two_q ? ST_SKIP2 : ST_SKIP1;
                    ST_SKIP2: state_next = ST_SKIP1;
                    default:  state_next = state;
                endcase
            end
        end
    end

    // Note gate; last note wins, note-off only releases the sounding key
    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            outIsPlaying <= 1'b0;
            outVelocity  <= '0;
            outNote      <= '0;
        end else if (note_on_c) begin
            outIsPlaying <= 1'b1;
            outVelocity  <= inMidiByte[6:0];
            outNote      <= key_q;
        end else if (note_off_c && (key_q == outNote)) begin
            outIsPlaying <= 1'b0;
        end
    end

    note_increment_rom u_rom (
        .key (outNote),
        .inc (inc_c)
    );

    assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign sum_c  = phase_q + inc_c;

    // Sample divider and oscillator; a tick uses pre-update gate, note and phase
    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            div_q          <= '0;
            phase_q        <= '0;
            outSample      <= SILENCE;
            outSampleReady <= 1'b0;
        end else begin
            div_q          <= tick_c ? '0 : div_q + DIV_W'(1);
            outSampleReady <= tick_c;
            if (tick_c) begin
                outSample <= outIsPlaying ? sum_c[PHASE_W-1 -: SAMPLE_W] : SILENCE;
            end
            if (note_on_c) begin
                phase_q <= '0;
            end else if (tick_c && outIsPlaying) begin
                phase_q <= sum_c;
            end
        end
    end

endmodule

// File: tb/tb_midi_note_gate.sv
// Directed bench for midi_note_gate with SAMPLE_DIV=4, CHANNEL=0 (honours MIDI_OMNI_EN).
`timescale 1ns/1ps
module tb_midi_note_gate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  midi_byte = 8'h00;
    logic        midi_rdy = 1'b0;
    logic [11:0] sample;
    logic        sample_rdy;
    logic        playing;
    logic [6:0]  velocity;
    logic [6:0]  note;

    int total = 0;
    int bad   = 0;

    midi_note_gate #(.SAMPLE_DIV(4), .CHANNEL(0)) dut (
        .inClk           (clk),
        .inResetN        (rst_n),
        .inMidiByte      (midi_byte),
        .inMidiByteReady (midi_rdy),
        .outSample       (sample),
        .outSampleReady  (sample_rdy),
        .outIsPlaying    (playing),
        .outVelocity     (velocity),
        .outNote         (note)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One cycle from negedge to negedge; byte sampled on the posedge between.
    task automatic cyc(input bit v, input logic [7:0] b);
        midi_byte = b;
        midi_rdy  = v;
        @(negedge clk);
        midi_rdy  = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        cyc(1, a); cyc(1, b); cyc(1, c);
    endtask

    // Advance to the next sample-ready pulse strictly after the current cycle.
    task automatic next_tick();
        bit found = 0;
        @(negedge clk);
        for (int i = 0; i < 8 && !found; i++) begin
            if (sample_rdy === 1'b1) found = 1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL tick_timeout got=none exp=pulse"); end
    endtask

    task automatic test_reset();
        int pulses = 0;
        int first = 0;
        int last = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (sample !== 12'h800) begin bad++; $display("FAIL rst_sample got=%h exp=800", sample); end
        total++; if (sample_rdy !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", sample_rdy); end
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL rst_playing got=%b exp=0", playing); end
        total++; if (velocity !== 7'd0) begin bad++; $display("FAIL rst_velocity got=%0d exp=0", velocity); end
        total++; if (note !== 7'd0) begin bad++; $display("FAIL rst_note got=%0d exp=0", note); end
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (sample_rdy === 1'b1) begin
                if (pulses == 0) first = i;
                else begin
                    total++;
                    if (i - last !== 4) begin bad++; $display("FAIL idle_spacing got=%0d exp=4", i - last); end
                end
                last = i;
                pulses++;
                total++; if (sample !== 12'h800) begin bad++; $display("FAIL idle_sample got=%h exp=800", sample); end
            end
            total++; if (playing !== 1'b0) begin bad++; $display("FAIL idle_playing got=%b exp=0", playing); end
        end
        total++; if (pulses !== 3) begin bad++; $display("FAIL idle_pulses got=%0d exp=3", pulses); end
        total++; if (first !== 4) begin bad++; $display("FAIL first_tick got=%0d exp=4", first); end
    endtask

    task automatic test_note_on();
        logic [11:0] exp_s [4] = '{12'd40, 12'd81, 12'd122, 12'd163};
        next_tick();
        send3(8'h90, 8'h45, 8'h64);
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL on_playing got=%b exp=1", playing); end
        total++; if (note !== 7'd69) begin bad++; $display("FAIL on_note got=%0d exp=69", note); end
        total++; if (velocity !== 7'd100) begin bad++; $display("FAIL on_velocity got=%0d exp=100", velocity); end
        for (int i = 0; i < 4; i++) begin
            next_tick();
            total++;
            if (sample !== exp_s[i]) begin bad++; $display("FAIL saw_step%0d got=%0d exp=%0d", i, sample, exp_s[i]); end
        end
    endtask

    task automatic test_running_status();
        send3(8'h90, 8'h3C, 8'h40);
        cyc(1, 8'h40); cyc(1, 8'h00);
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL rs_playing got=%b exp=1", playing); end
        total++; if (note !== 7'd60) begin bad++; $display("FAIL rs_note got=%0d exp=60", note); end
        total++; if (velocity !== 7'd64) begin bad++; $display("FAIL rs_velocity got=%0d exp=64", velocity); end
        send3(8'h80, 8'h3C, 8'h00);
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL off_playing got=%b exp=0", playing); end
        total++; if (note !== 7'd60) begin bad++; $display("FAIL off_note got=%0d exp=60", note); end
        total++; if (velocity !== 7'd64) begin bad++; $display("FAIL off_velocity got=%0d exp=64", velocity); end
        next_tick();
        total++; if (sample !== 12'h800) begin bad++; $display("FAIL off_sample got=%h exp=800", sample); end
    endtask

    task automatic test_realtime_and_prog();
        cyc(1, 8'h90); cyc(1, 8'h3C); cyc(1, 8'hF8); cyc(1, 8'h50);
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL rt_playing got=%b exp=1", playing); end
        total++; if (note !== 7'd60) begin bad++; $display("FAIL rt_note got=%0d exp=60", note); end
        total++; if (velocity !== 7'd80) begin bad++; $display("FAIL rt_velocity got=%0d exp=80", velocity); end
        send3(8'hC0, 8'h05, 8'h07);
        cyc(1, 8'h3C); cyc(1, 8'h00);
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL prog_playing got=%b exp=1", playing); end
        total++; if (note !== 7'd60) begin bad++; $display("FAIL prog_note got=%0d exp=60", note); end
        total++; if (velocity !== 7'd80) begin bad++; $display("FAIL prog_velocity got=%0d exp=80", velocity); end
    endtask

    task automatic test_skip_and_channel();
        send3(8'h80, 8'h3C, 8'h00);
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL pre_ch_playing got=%b exp=0", playing); end
        send3(8'hB0, 8'h07, 8'h64);
        cyc(1, 8'h3C); cyc(1, 8'h40);
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL cc_playing got=%b exp=0", playing); end
        send3(8'h91, 8'h3C, 8'h40);
`ifdef MIDI_OMNI_EN
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL ch1_playing got=%b exp=1", playing); end
        total++; if (velocity !== 7'd64) begin bad++; $display("FAIL ch1_velocity got=%0d exp=64", velocity); end
`else
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL ch1_playing got=%b exp=0", playing); end
        total++; if (velocity !== 7'd80) begin bad++; $display("FAIL ch1_velocity got=%0d exp=80", velocity); end
`endif
        send3(8'h80, 8'h3C, 8'h00);
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL post_ch_playing got=%b exp=0", playing); end
    endtask

    task automatic test_collision();
        next_tick();
        cyc(1, 8'h90); cyc(1, 8'h3C); cyc(0, 8'h00); cyc(1, 8'h40);
        total++; if (sample_rdy !== 1'b1) begin bad++; $display("FAIL col_ready got=%b exp=1", sample_rdy); end
        total++; if (sample !== 12'h800) begin bad++; $display("FAIL col_sample got=%h exp=800", sample); end
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL col_playing got=%b exp=1", playing); end
        next_tick();
        total++; if (sample !== 12'd24) begin bad++; $display("FAIL col_next got=%0d exp=24", sample); end
        next_tick();
        total++; if (sample !== 12'd48) begin bad++; $display("FAIL col_next2 got=%0d exp=48", sample); end
    endtask

    task automatic test_reset_mid();
        int wait_n = 0;
        cyc(1, 8'h90); cyc(1, 8'h45);
        rst_n = 1'b0;
        #1;
        total++; if (sample !== 12'h800) begin bad++; $display("FAIL mid_sample got=%h exp=800", sample); end
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL mid_playing got=%b exp=0", playing); end
        total++; if (note !== 7'd0) begin bad++; $display("FAIL mid_note got=%0d exp=0", note); end
        total++; if (velocity !== 7'd0) begin bad++; $display("FAIL mid_velocity got=%0d exp=0", velocity); end
        total++; if (sample_rdy !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", sample_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8 && wait_n == 0; i++) begin
            @(negedge clk);
            if (sample_rdy === 1'b1) wait_n = i;
        end
        total++; if (wait_n !== 4) begin bad++; $display("FAIL mid_first_tick got=%0d exp=4", wait_n); end
        cyc(1, 8'h64);
        total++; if (playing !== 1'b0) begin bad++; $display("FAIL mid_stale_vel got=%b exp=0", playing); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime_and_prog();
        test_skip_and_channel();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
